// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: boot-time instruction memory loader and core sequencer.
// Parses a little-endian 16-bit word-count header from a byte stream and
// assembles LSB-first 32-bit words. Each word is written to addresses 0..N-1.
// The core stays stalled until the whole image has been written.
// Optional macro IMEM_LOAD_CHECKSUM_EN adds a trailing XOR checksum byte.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   rx_valid/rx_data  incoming stream byte; rx_ready accepts it (combinational)
//   load_start        reload request, honoured in RUN or ERR only
//   mem_we/mem_waddr/mem_wdata  instruction memory write port (registered)
//   core_stall        high in every state except RUN
//   load_done         one-cycle pulse in DONE
//   load_err          high while in ERR
//   words_loaded      words written since the last (re)start
module imem_load_ctrl #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              load_start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              core_stall,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W = 16;

`ifdef IMEM_LOAD_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE, S_RUN, S_ERR
  } state_t;
  localparam state_t S_PAY_END = S_CSUM;
`else
  typedef enum logic [2:0] {
    S_HDR0, S_HDR1, S_DATA, S_DONE, S_RUN, S_ERR
  } state_t;
  localparam state_t S_PAY_END = S_DONE;
`endif

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         cnt_lo;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         byte_idx;
  logic [23:0]        asm_q;
  logic               accept;
  logic [CNT_W-1:0]   hdr_n;
  logic               last_word;
  logic               restart;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]         csum;
`endif

  assign accept    = rx_valid && rx_ready;
  assign hdr_n     = {rx_data, cnt_lo};
  assign last_word = (CNT_W'(words_loaded) + CNT_W'(1)) == cnt;
  assign restart   = load_start && (state == S_RUN || state == S_ERR);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_HDR0;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR0: if (accept) state_nxt = S_HDR1;
      S_HDR1: begin
        if (accept) begin
          if (hdr_n == '0)                  state_nxt = S_PAY_END;
          else if (hdr_n > CNT_W'(DEPTH))   state_nxt = S_ERR;
          else                              state_nxt = S_DATA;
        end
      end
      S_DATA: if (accept && byte_idx == 2'd3 && last_word) state_nxt = S_PAY_END;
`ifdef IMEM_LOAD_CHECKSUM_EN
      S_CSUM: if (accept) state_nxt = (rx_data == csum) ? S_DONE : S_ERR;
`endif
      S_DONE: state_nxt = S_RUN;
      S_RUN:  if (load_start) state_nxt = S_HDR0;
      S_ERR:  if (load_start) state_nxt = S_HDR0;
      default: state_nxt = S_HDR0;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    rx_ready   = 1'b0;
    core_stall = 1'b1;
    load_done  = 1'b0;
    load_err   = 1'b0;
    case (state)
      S_HDR0, S_HDR1, S_DATA: rx_ready = 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
      S_CSUM: rx_ready = 1'b1;
`endif
      S_DONE: load_done  = 1'b1;
      S_RUN:  core_stall = 1'b0;
      S_ERR:  load_err   = 1'b1;
      default: ;
    endcase
  end

  // Header capture, word assembly and registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_lo       <= '0;
      cnt          <= '0;
      byte_idx     <= '0;
      asm_q        <= '0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (restart) begin
        byte_idx     <= '0;
        words_loaded <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
        csum         <= '0;
`endif
      end
      if (accept) begin
        case (state)
          S_HDR0: cnt_lo <= rx_data;
          S_HDR1: cnt    <= hdr_n;
          S_DATA: begin
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum     <= csum ^ rx_data;
`endif
            // Fourth byte completes the word; strobe it out next cycle
            if (byte_idx == 2'd3) begin
              mem_we       <= 1'b1;
              mem_waddr    <= words_loaded[ADDR_W-1:0];
              mem_wdata    <= {rx_data, asm_q};
              words_loaded <= words_loaded + (ADDR_W+1)'(1);
            end else begin
              asm_q <= {rx_data, asm_q[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Boot-time program loader and sequencer for the instruction memory. Accepts a byte stream, parses a word-count header, assembles little-endian 32-bit instruction words and drives them into the instruction memory write port. Holds the core stalled until the image is complete, then releases it. Sits between the host byte link (UART/debug receiver) and the instruction memory, alongside the fetch path.

## Interface
- DEPTH, 256: instruction memory size in 32-bit words.
- ADDR_W, 8: word-address width; must equal clog2(DEPTH).

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  stream byte.
- rx_ready  out  1  byte accepted when rx_valid && rx_ready at a rising edge.
- load_start  in  1  one-cycle request to reload; honoured only in RUN or ERR.
- mem_we  out  1  instruction memory write strobe, one cycle per word.
- mem_waddr  out  ADDR_W  word address for the write.
- mem_wdata  out  32  instruction word.
- core_stall  out  1  high in every state except RUN.
- load_done  out  1  one-cycle pulse when the image is complete.
- load_err  out  1  level, high while in ERR.
- words_loaded  out  ADDR_W+1  words written since the last (re)start.

## Operation
- Stream format: CNT_LO, CNT_HI (16-bit word count N, little-endian), then 4*N payload bytes, each word LSB first, written to addresses 0..N-1.
- States: HDR0, HDR1, DATA, CSUM (macro only), DONE, RUN, ERR. Reset enters HDR0.
- rx_ready is combinational: 1 in HDR0/HDR1/DATA/CSUM, 0 in DONE/RUN/ERR.
- HDR0: accept byte -> CNT_LO, go HDR1.
- HDR1: accept byte -> CNT_HI. N = 0 -> DONE (CSUM if macro). N > DEPTH -> ERR. Otherwise -> DATA.
- DATA: 2-bit byte index shifts bytes into word assembly. On the 4th byte, register mem_wdata = {b3,b2,b1,b0} and mem_waddr = current word index, and assert mem_we for exactly the next cycle. Word index and words_loaded increment with that strobe. After the word N-1 byte is accepted -> DONE (CSUM if macro).
- DONE: one cycle; load_done = 1 and core_stall stays 1. This cycle coincides with the final mem_we, so the last write completes before the core is released. Next state is RUN.
- RUN: core_stall = 0. load_start -> HDR0, clearing the byte index, word index and words_loaded. Memory contents are untouched.
- ERR: core_stall = 1, load_err = 1, no writes. Exits only on load_start (-> HDR0) or reset.
- load_start is ignored in HDR0/HDR1/DATA/CSUM/DONE.
- Reset mid-load: returns to HDR0 next cycle. A pending mem_we is cancelled and counters clear. Words already written stay in memory.

## Timing
- Reset values: rx_ready 1, mem_we 0, mem_waddr 0, mem_wdata 0, core_stall 1, load_done 0, load_err 0, words_loaded 0.
- Write latency: mem_we rises the cycle after the 4th byte of a word is accepted.
- Throughput: one byte per cycle maximum; rx_valid gaps of any length are tolerated with no state change.
- core_stall falls 2 cycles after the final byte is accepted (1 DONE cycle, then RUN).
- mem_waddr and mem_wdata hold their last values while mem_we = 0.

## Configuration
- IMEM_LOAD_CHECKSUM_EN defined:
  - After the payload (or after HDR1 when N = 0), CSUM accepts one byte. This byte must equal the XOR of all payload bytes; the XOR accumulator is 0 for an empty payload.
  - Match -> DONE. Mismatch -> ERR; written words remain in memory.
  - The final word's mem_we occurs during the first CSUM cycle.
- IMEM_LOAD_CHECKSUM_EN undefined: no CSUM state and no accumulator; the payload end goes directly to DONE.

## Test plan
- Reset, then stream 02 00 13 00 00 00 93 00 10 00 back-to-back:
  - mem_we at addr 0 with 0x00000013, then at addr 1 with 0x00100093.
  - load_done pulses once; core_stall falls 2 cycles after the last byte; words_loaded = 2; rx_ready = 0.
- Same stream with random 0-5 cycle rx_valid gaps -> identical writes and final state; no byte lost or duplicated.
- Header 01 01 (N = 257, DEPTH = 256) -> ERR after the 2nd byte: load_err = 1, rx_ready = 0, no mem_we. Then load_start -> HDR0, load_err = 0.
- Header 00 00 -> DONE then RUN with zero writes; words_loaded = 0.
- Assert reset after 6 payload bytes of a 2-word load:
  - addr 0 keeps its write; no write to addr 1.
  - A fresh 1-word stream then writes addr 0 and reaches RUN.
- IMEM_LOAD_CHECKSUM_EN defined, stream 01 00 13 00 00 00 followed by checksum byte:
  - Checksum 13 -> RUN.
  - Checksum 12 -> ERR with core_stall held at 1.
